// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: MEM-stage commit bus from the datapath into the pipeline control unit.
interface pipe_ctrl_if #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  mem_en;
  logic                  mem_busy;
  logic [ADDR_W-1:0]     mem_pc;
  logic [1:0]            mem_ctrl_op;
  logic [2:0]            mem_exp_code;
  logic [REG_ADDR_W-1:0] mem_dst_addr;
  logic [WORD_W-1:0]     mem_out;

  modport master (
    output mem_en, mem_busy, mem_pc, mem_ctrl_op, mem_exp_code, mem_dst_addr, mem_out
  );

  modport slave (
    input mem_en, mem_busy, mem_pc, mem_ctrl_op, mem_exp_code, mem_dst_addr, mem_out
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush generation, MEM-stage exception/EXRT commit, control registers, irq sync.
// Optional HALT state is built only when PIPE_CTRL_HALT_EN is defined.
module pipe_ctrl #(
  parameter int unsigned       WORD_W         = 32,
  parameter int unsigned       ADDR_W         = 30,
  parameter int unsigned       REG_ADDR_W     = 5,
  parameter int unsigned       IRQ_W          = 8,
  parameter logic [ADDR_W-1:0] EXP_VECTOR_RST = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IRQ_W-1:0]      irq,
  input  logic                  ld_hazard,
  input  logic                  if_busy,
  pipe_ctrl_if.slave            bus,
  input  logic [REG_ADDR_W-1:0] creg_rd_addr,
  output logic [WORD_W-1:0]     creg_rd_data,
  output logic                  exe_mode,
  output logic                  int_detect,
  output logic                  if_stall,
  output logic                  id_stall,
  output logic                  ex_stall,
  output logic                  mem_stall,
  output logic                  if_flush,
  output logic                  id_flush,
  output logic                  ex_flush,
  output logic                  mem_flush,
  output logic [ADDR_W-1:0]     new_pc
);

  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_EXRT = 2'd2;

  localparam logic [REG_ADDR_W-1:0] CR_STATUS     = REG_ADDR_W'(0);
  localparam logic [REG_ADDR_W-1:0] CR_PRE_STATUS = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] CR_EPC        = REG_ADDR_W'(2);
  localparam logic [REG_ADDR_W-1:0] CR_EXP_VECTOR = REG_ADDR_W'(3);
  localparam logic [REG_ADDR_W-1:0] CR_CAUSE      = REG_ADDR_W'(4);
  localparam logic [REG_ADDR_W-1:0] CR_INT_MASK   = REG_ADDR_W'(5);
  localparam logic [REG_ADDR_W-1:0] CR_INT_PEND   = REG_ADDR_W'(6);

  logic [1:0]        status;
  logic [1:0]        pre_status;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] exp_vector;
  logic [2:0]        cause;
  logic [IRQ_W-1:0]  int_mask;
  logic [IRQ_W-1:0]  irq_meta;
  logic [IRQ_W-1:0]  int_pend;

  logic              run;
  logic              resume;
  logic [ADDR_W-1:0] resume_pc;
  logic              commit;
  logic              no_exp;
  logic              take_exp;
  logic              take_exrt;
  logic              take_wrcr;
  logic              flush_all;
  logic              stall_all;
  logic              unused_mem_out_hi;

  assign unused_mem_out_hi = ^bus.mem_out[WORD_W-1:ADDR_W];

`ifdef PIPE_CTRL_HALT_EN
  localparam logic [1:0] OP_HALT = 2'd3;

  typedef enum logic {ST_RUN, ST_HALT} state_t;
  state_t state;
  logic   take_halt;

  assign run       = (state == ST_RUN);
  assign resume    = reset & (state == ST_HALT) & int_detect;
  assign resume_pc = bus.mem_pc + ADDR_W'(1);
  assign take_halt = commit & no_exp & (bus.mem_ctrl_op == OP_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:  if (take_halt) state <= ST_HALT;
        ST_HALT: if (int_detect) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end
`else
  assign run       = 1'b1;
  assign resume    = 1'b0;
  assign resume_pc = '0;
`endif

  // Everything is gated by reset so outputs drop the instant reset asserts, even mid-stall.
  always_comb begin
    commit    = reset & bus.mem_en & ~bus.mem_busy & run;
    no_exp    = (bus.mem_exp_code == 3'd0);
    take_exp  = commit & ~no_exp;
    take_exrt = commit & no_exp & (bus.mem_ctrl_op == OP_EXRT);
    take_wrcr = commit & no_exp & (bus.mem_ctrl_op == OP_WRCR);
    flush_all = take_exp | take_exrt | resume;
    stall_all = reset & ~flush_all & (~run | if_busy | bus.mem_busy | ld_hazard);

    if_stall  = stall_all;
    id_stall  = stall_all;
    ex_stall  = stall_all;
    mem_stall = stall_all;
    if_flush  = flush_all;
    id_flush  = flush_all;
    ex_flush  = flush_all | (reset & run & ld_hazard);
    mem_flush = flush_all;

    if (take_exp)       new_pc = exp_vector;
    else if (take_exrt) new_pc = epc;
    else if (resume)    new_pc = resume_pc;
    else                new_pc = '0;
  end

  always_comb begin
    creg_rd_data = '0;
    case (creg_rd_addr)
      CR_STATUS:     creg_rd_data[1:0]        = status;
      CR_PRE_STATUS: creg_rd_data[1:0]        = pre_status;
      CR_EPC:        creg_rd_data[ADDR_W-1:0] = epc;
      CR_EXP_VECTOR: creg_rd_data[ADDR_W-1:0] = exp_vector;
      CR_CAUSE:      creg_rd_data[2:0]        = cause;
      CR_INT_MASK:   creg_rd_data[IRQ_W-1:0]  = int_mask;
      CR_INT_PEND:   creg_rd_data[IRQ_W-1:0]  = int_pend;
      default:       ;
    endcase
  end

  assign exe_mode = status[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status     <= '0;
      pre_status <= '0;
      epc        <= '0;
      exp_vector <= EXP_VECTOR_RST;
      cause      <= '0;
      int_mask   <= '1;
      irq_meta   <= '0;
      int_pend   <= '0;
      int_detect <= 1'b0;
    end else begin
      irq_meta   <= irq;
      int_pend   <= irq_meta;
      int_detect <= status[1] & |(int_pend & ~int_mask);
      if (take_exp) begin
        pre_status <= status;
        status     <= '0;
        epc        <= bus.mem_pc;
        cause      <= bus.mem_exp_code;
      end else if (take_exrt) begin
        status <= pre_status;
      end else if (take_wrcr) begin
        case (bus.mem_dst_addr)
          CR_STATUS:     status     <= bus.mem_out[1:0];
          CR_PRE_STATUS: pre_status <= bus.mem_out[1:0];
          CR_EPC:        epc        <= bus.mem_out[ADDR_W-1:0];
          CR_EXP_VECTOR: exp_vector <= bus.mem_out[ADDR_W-1:0];
          CR_CAUSE:      cause      <= bus.mem_out[2:0];
          CR_INT_MASK:   int_mask   <= bus.mem_out[IRQ_W-1:0];
          default:       ;
        endcase
      end else if (resume) begin
        epc <= resume_pc;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic checked against a creg-array reference model.
module tb_pipe_ctrl;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_W     = 30;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned IRQ_W      = 8;
  localparam logic [ADDR_W-1:0] EVR  = 'h123;
  localparam int unsigned AMASK      = 32'h3FFF_FFFF;
`ifdef PIPE_CTRL_HALT_EN
  localparam int unsigned RAND_OP_MAX = 2;
`else
  localparam int unsigned RAND_OP_MAX = 3;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [IRQ_W-1:0]      irq;
  logic                  ld_hazard, if_busy;
  logic [REG_ADDR_W-1:0] creg_rd_addr;
  logic [WORD_W-1:0]     creg_rd_data;
  logic                  exe_mode, int_detect;
  logic                  if_stall, id_stall, ex_stall, mem_stall;
  logic                  if_flush, id_flush, ex_flush, mem_flush;
  logic [ADDR_W-1:0]     new_pc;
  logic [3:0]            stalls, flushes;

  int checks = 0;
  int errors = 0;

  // reference model: creg array indexed by address, cr[6] holds INT_PEND
  int unsigned m_cr[8];
  logic [7:0]  m_d1;
  bit          m_det;
  bit          m_halt;

  pipe_ctrl_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  pipe_ctrl #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W), .IRQ_W(IRQ_W), .EXP_VECTOR_RST(EVR)
  ) dut (
    .clk(clk), .reset(reset), .irq(irq), .ld_hazard(ld_hazard), .if_busy(if_busy), .bus(bus),
    .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data), .exe_mode(exe_mode),
    .int_detect(int_detect), .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
    .mem_flush(mem_flush), .new_pc(new_pc)
  );

  assign stalls  = {if_stall, id_stall, ex_stall, mem_stall};
  assign flushes = {if_flush, id_flush, ex_flush, mem_flush};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic int unsigned wmask(int unsigned a);
    case (a)
      0, 1:    return 3;
      2, 3:    return AMASK;
      4:       return 7;
      5:       return 'hFF;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_cr[i]) m_cr[i] = 0;
    m_cr[3] = EVR;
    m_cr[5] = 'hFF;
    m_d1    = '0;
    m_det   = 0;
    m_halt  = 0;
  endtask

  task automatic model_update();
    bit commit, exc, exrt, resume, new_det;
    int unsigned pc;
    pc      = bus.mem_pc;
    commit  = bus.mem_en && !bus.mem_busy && !m_halt;
    exc     = commit && bus.mem_exp_code != 0;
    exrt    = commit && bus.mem_exp_code == 0 && bus.mem_ctrl_op == 2;
    resume  = m_halt && m_det;
    new_det = ((m_cr[0] >> 1) & 1) != 0 && ((m_cr[6] & ~m_cr[5] & 'hFF) != 0);
    if (exc) begin
      m_cr[1] = m_cr[0]; m_cr[0] = 0; m_cr[2] = pc; m_cr[4] = bus.mem_exp_code;
    end else if (exrt) begin
      m_cr[0] = m_cr[1];
    end else if (commit && bus.mem_exp_code == 0 && bus.mem_ctrl_op == 1 && bus.mem_dst_addr < 6) begin
      m_cr[bus.mem_dst_addr] = bus.mem_out & wmask(bus.mem_dst_addr);
    end
    if (resume) begin
      m_cr[2] = (pc + 1) & AMASK;
      m_halt  = 0;
    end
`ifdef PIPE_CTRL_HALT_EN
    else if (commit && bus.mem_exp_code == 0 && bus.mem_ctrl_op == 3) m_halt = 1;
`endif
    m_cr[6] = m_d1;
    m_d1    = irq;
    m_det   = new_det;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ld_hazard = 0; if_busy = 0;
    bus.mem_en = 0; bus.mem_busy = 0; bus.mem_pc = '0; bus.mem_ctrl_op = 0;
    bus.mem_exp_code = 0; bus.mem_dst_addr = '0; bus.mem_out = '0;
  endtask

  task automatic drive_commit(input logic [1:0] op, input logic [2:0] code, input logic [ADDR_W-1:0] pc,
                              input logic [REG_ADDR_W-1:0] dst, input logic [WORD_W-1:0] data);
    drive_idle();
    bus.mem_en = 1; bus.mem_ctrl_op = op; bus.mem_exp_code = code; bus.mem_pc = pc;
    bus.mem_dst_addr = dst; bus.mem_out = data;
  endtask

  task automatic test_reset();
    reset = 0; irq = 'hFF; creg_rd_addr = 3;
    drive_commit(2'd2, 3'd3, 'h10, 0, 0);
    ld_hazard = 1; if_busy = 1;
    #2;
    checks++; if (stalls !== 4'h0) begin errors++; $display("FAIL rst_stalls got %h want 0", stalls); end
    checks++; if (flushes !== 4'h0) begin errors++; $display("FAIL rst_flushes got %h want 0", flushes); end
    checks++; if (new_pc !== '0) begin errors++; $display("FAIL rst_new_pc got %h want 0", new_pc); end
    @(posedge clk); @(posedge clk); #1;
    drive_idle();
    reset = 1;
    model_reset();
    #1;
    checks++; if (exe_mode !== 1'b0) begin errors++; $display("FAIL rst_exe_mode got %b want 0", exe_mode); end
    checks++; if (int_detect !== 1'b0) begin errors++; $display("FAIL rst_int_detect got %b want 0", int_detect); end
    checks++; if (creg_rd_data !== 32'(EVR)) begin errors++; $display("FAIL rst_exp_vector got %h want %h", creg_rd_data, EVR); end
    creg_rd_addr = 5; #1;
    checks++; if (creg_rd_data !== 32'hFF) begin errors++; $display("FAIL rst_int_mask got %h want ff", creg_rd_data); end
    @(posedge clk); #1;
    irq = '0;
    if_busy = 1; #1;
    checks++; if (stalls !== 4'hF) begin errors++; $display("FAIL pre_rst_stall got %h want f", stalls); end
    reset = 0; #1;
    checks++; if (stalls !== 4'h0) begin errors++; $display("FAIL mid_stall_rst got %h want 0", stalls); end
    @(posedge clk); #1;
    drive_idle();
    reset = 1;
    model_reset();
    #1;
  endtask

  task automatic test_ld_hazard();
    drive_idle(); ld_hazard = 1; #1;
    checks++; if (stalls !== 4'hF) begin errors++; $display("FAIL ld_stalls got %h want f", stalls); end
    checks++; if (flushes !== 4'b0010) begin errors++; $display("FAIL ld_flushes got %b want 0010", flushes); end
    tick();
    ld_hazard = 0; #1;
    checks++; if (stalls !== 4'h0) begin errors++; $display("FAIL ld_after_stalls got %h want 0", stalls); end
    checks++; if (flushes !== 4'h0) begin errors++; $display("FAIL ld_after_flushes got %h want 0", flushes); end
  endtask

  task automatic test_exception();
    drive_commit(2'd1, 3'd0, 'h1, 0, 'h1); tick();
    drive_commit(2'd1, 3'd0, 'h2, 3, 'h100); creg_rd_addr = 3; #1;
    checks++; if (creg_rd_data !== 32'(EVR)) begin errors++; $display("FAIL wrcr_no_bypass got %h want %h", creg_rd_data, EVR); end
    tick();
    drive_idle(); #1;
    checks++; if (creg_rd_data !== 32'h100) begin errors++; $display("FAIL wrcr_vec got %h want 100", creg_rd_data); end
    // overflow carrying a WRCR op: the exception must win
    drive_commit(2'd1, 3'd3, 'h40, 3, 'h555); #1;
    checks++; if (flushes !== 4'hF) begin errors++; $display("FAIL exc_flushes got %h want f", flushes); end
    checks++; if (new_pc !== ADDR_W'('h100)) begin errors++; $display("FAIL exc_new_pc got %h want 100", new_pc); end
    tick();
    drive_idle(); #1;
    checks++; if (flushes !== 4'h0) begin errors++; $display("FAIL exc_one_cycle got %h want 0", flushes); end
    creg_rd_addr = 2; #1;
    checks++; if (creg_rd_data !== 32'h40) begin errors++; $display("FAIL exc_epc got %h want 40", creg_rd_data); end
    creg_rd_addr = 4; #1;
    checks++; if (creg_rd_data !== 32'h3) begin errors++; $display("FAIL exc_cause got %h want 3", creg_rd_data); end
    creg_rd_addr = 1; #1;
    checks++; if (creg_rd_data !== 32'h1) begin errors++; $display("FAIL exc_pre_status got %h want 1", creg_rd_data); end
    creg_rd_addr = 3; #1;
    checks++; if (creg_rd_data !== 32'h100) begin errors++; $display("FAIL exc_vec_kept got %h want 100", creg_rd_data); end
    checks++; if (exe_mode !== 1'b0) begin errors++; $display("FAIL exc_kernel got %b want 0", exe_mode); end
  endtask

  task automatic test_exrt();
    drive_commit(2'd1, 3'd0, 'h70, 0, 'h3); tick();
    drive_idle(); #1;
    checks++; if (exe_mode !== 1'b1) begin errors++; $display("FAIL exrt_user got %b want 1", exe_mode); end
    drive_commit(2'd0, 3'd5, 'h77, 0, 0); tick();
    drive_idle(); #1;
    checks++; if (exe_mode !== 1'b0) begin errors++; $display("FAIL trap_kernel got %b want 0", exe_mode); end
    drive_commit(2'd2, 3'd0, 'h99, 0, 0); #1;
    checks++; if (flushes !== 4'hF) begin errors++; $display("FAIL exrt_flushes got %h want f", flushes); end
    checks++; if (new_pc !== ADDR_W'('h77)) begin errors++; $display("FAIL exrt_new_pc got %h want 77", new_pc); end
    tick();
    drive_idle(); creg_rd_addr = 0; #1;
    checks++; if (creg_rd_data !== 32'h3) begin errors++; $display("FAIL exrt_status got %h want 3", creg_rd_data); end
    checks++; if (exe_mode !== 1'b1) begin errors++; $display("FAIL exrt_exe_mode got %b want 1", exe_mode); end
  endtask

  task automatic test_irq();
    bit cleared;
    drive_commit(2'd1, 3'd0, 'h5, 5, 'hFE); tick();
    drive_idle(); creg_rd_addr = 6;
    irq = 8'h01;
    tick();
    checks++; if (int_detect !== 1'b0) begin errors++; $display("FAIL irq_lat1 got %b want 0", int_detect); end
    tick();
    checks++; if (int_detect !== 1'b0) begin errors++; $display("FAIL irq_lat2 got %b want 0", int_detect); end
    checks++; if (creg_rd_data !== 32'h1) begin errors++; $display("FAIL irq_pend got %h want 1", creg_rd_data); end
    tick();
    checks++; if (int_detect !== 1'b1) begin errors++; $display("FAIL irq_lat3 got %b want 1", int_detect); end
    irq = '0;
    cleared = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (!int_detect) begin cleared = 1; break; end
    end
    checks++; if (!cleared) begin errors++; $display("FAIL irq_clear got %b want 0", int_detect); end
    irq = 8'h02;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (int_detect !== 1'b0) begin errors++; $display("FAIL irq_masked got %b want 0", int_detect); end
    end
    irq = '0;
    repeat (3) tick();
  endtask

  task automatic test_busy_exception();
    drive_commit(2'd0, 3'd4, 'h20, 0, 0);
    bus.mem_busy = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (stalls !== 4'hF) begin errors++; $display("FAIL busy_stalls got %h want f", stalls); end
      checks++; if (flushes !== 4'h0) begin errors++; $display("FAIL busy_flushes got %h want 0", flushes); end
      tick();
    end
    bus.mem_busy = 0; #1;
    checks++; if (flushes !== 4'hF) begin errors++; $display("FAIL busy_drop_flush got %h want f", flushes); end
    checks++; if (new_pc !== ADDR_W'('h100)) begin errors++; $display("FAIL busy_new_pc got %h want 100", new_pc); end
    tick();
    drive_idle(); creg_rd_addr = 2; #1;
    checks++; if (creg_rd_data !== 32'h20) begin errors++; $display("FAIL busy_epc got %h want 20", creg_rd_data); end
  endtask

  task automatic test_halt();
`ifdef PIPE_CTRL_HALT_EN
    bit seen;
    drive_commit(2'd1, 3'd0, 'h4, 0, 'h2); tick();
    drive_commit(2'd3, 3'd0, 'h50, 0, 0); #1;
    checks++; if (flushes !== 4'h0) begin errors++; $display("FAIL halt_commit_flush got %h want 0", flushes); end
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (stalls !== 4'hF) begin errors++; $display("FAIL halt_stalls got %h want f", stalls); end
      checks++; if (flushes !== 4'h0) begin errors++; $display("FAIL halt_flushes got %h want 0", flushes); end
      tick();
    end
    irq = 8'h01;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (int_detect) begin seen = 1; break; end
      checks++; if (stalls !== 4'hF) begin errors++; $display("FAIL halt_wait_stalls got %h want f", stalls); end
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL halt_wake got %b want 1", int_detect); end
    checks++; if (flushes !== 4'hF) begin errors++; $display("FAIL resume_flush got %h want f", flushes); end
    checks++; if (new_pc !== ADDR_W'('h51)) begin errors++; $display("FAIL resume_pc got %h want 51", new_pc); end
    tick();
    drive_idle(); creg_rd_addr = 2; #1;
    checks++; if (stalls !== 4'h0) begin errors++; $display("FAIL resume_run got %h want 0", stalls); end
    checks++; if (creg_rd_data !== 32'h51) begin errors++; $display("FAIL resume_epc got %h want 51", creg_rd_data); end
    irq = '0;
    repeat (3) tick();
`else
    drive_commit(2'd3, 3'd0, 'h50, 0, 0); #1;
    checks++; if (flushes !== 4'h0) begin errors++; $display("FAIL halt_nop_flush got %h want 0", flushes); end
    tick(); #1;
    checks++; if (stalls !== 4'h0) begin errors++; $display("FAIL halt_nop_stall got %h want 0", stalls); end
    tick();
    drive_idle(); #1;
    checks++; if (stalls !== 4'h0) begin errors++; $display("FAIL halt_nop_after got %h want 0", stalls); end
`endif
  endtask

  task automatic test_random();
    bit commit, exc, exrt, resume, fa;
    logic [3:0] e_st, e_fl;
    int unsigned e_pc, e_rd, pc;
    for (int n = 0; n < 400; n++) begin
      ld_hazard        = ($urandom_range(0, 3) == 0);
      if_busy          = ($urandom_range(0, 3) == 0);
      bus.mem_busy     = ($urandom_range(0, 3) == 0);
      bus.mem_en       = ($urandom_range(0, 1) == 1);
      bus.mem_pc       = ADDR_W'($urandom);
      bus.mem_ctrl_op  = 2'($urandom_range(0, RAND_OP_MAX));
      bus.mem_exp_code = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
      bus.mem_dst_addr = REG_ADDR_W'($urandom_range(0, 7));
      bus.mem_out      = $urandom;
      creg_rd_addr     = REG_ADDR_W'($urandom_range(0, 8));
      if ($urandom_range(0, 7) == 0) irq = 8'($urandom);
      #1;
      pc     = bus.mem_pc;
      commit = bus.mem_en && !bus.mem_busy && !m_halt;
      exc    = commit && bus.mem_exp_code != 0;
      exrt   = commit && bus.mem_exp_code == 0 && bus.mem_ctrl_op == 2;
      resume = m_halt && m_det;
      fa     = exc || exrt || resume;
      e_st   = (!fa && (m_halt || if_busy || bus.mem_busy || ld_hazard)) ? 4'hF : 4'h0;
      e_fl   = fa ? 4'hF : ((!m_halt && ld_hazard) ? 4'b0010 : 4'h0);
      e_pc   = exc ? m_cr[3] : exrt ? m_cr[2] : resume ? ((pc + 1) & AMASK) : 0;
      e_rd   = (creg_rd_addr < 7) ? m_cr[creg_rd_addr] : 0;
      checks++; if (stalls !== e_st) begin errors++; $display("FAIL rnd_stalls n=%0d got %h want %h", n, stalls, e_st); end
      checks++; if (flushes !== e_fl) begin errors++; $display("FAIL rnd_flushes n=%0d got %h want %h", n, flushes, e_fl); end
      checks++; if (new_pc !== ADDR_W'(e_pc)) begin errors++; $display("FAIL rnd_new_pc n=%0d got %h want %h", n, new_pc, e_pc); end
      checks++; if (creg_rd_data !== e_rd) begin errors++; $display("FAIL rnd_creg n=%0d addr=%0d got %h want %h", n, creg_rd_addr, creg_rd_data, e_rd); end
      checks++; if (exe_mode !== m_cr[0][0]) begin errors++; $display("FAIL rnd_exe_mode n=%0d got %b want %b", n, exe_mode, m_cr[0][0]); end
      checks++; if (int_detect !== m_det) begin errors++; $display("FAIL rnd_int_detect n=%0d got %b want %b", n, int_detect, m_det); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ld_hazard();
    test_exception();
    test_exrt();
    test_irq();
    test_busy_exception();
    test_halt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage CPU. It generates stall and flush for the IF/ID/EX/MEM registers from load hazards and memory busy.
- It commits exceptions and EXRT at the MEM stage, and redirects the PC on those commits.
- It owns the control-register file read by the ID stage (creg_rd_addr/creg_rd_data) and produces exe_mode.
- It synchronises and masks external interrupts and reports a pending interrupt to decode.

Parameters:
- WORD_W, 32, data word width
- ADDR_W, 30, word-address width
- REG_ADDR_W, 5, register address width
- IRQ_W, 8, external interrupt lines
- EXP_VECTOR_RST, 0, reset value of EXP_VECTOR creg (word address)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- irq  in  IRQ_W  external interrupt lines, asynchronous
- ld_hazard  in  1  load-use hazard from ID
- if_busy  in  1  instruction fetch not complete
- mem_busy  in  1  data access not complete
- mem_en  in  1  MEM stage holds a valid instruction
- mem_pc  in  ADDR_W  PC of MEM-stage instruction
- mem_ctrl_op  in  2  0 NOP, 1 WRCR, 2 EXRT, 3 HALT
- mem_exp_code  in  3  0 none, 1 ext int, 2 undef, 3 overflow, 4 misalign, 5 trap, 6 privilege
- mem_dst_addr  in  REG_ADDR_W  creg write address
- mem_out  in  WORD_W  creg write data
- creg_rd_addr  in  REG_ADDR_W  creg read address from ID
- creg_rd_data  out  WORD_W  creg read data
- exe_mode  out  1  0 kernel, 1 user
- int_detect  out  1  unmasked interrupt pending and enabled
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage stalls
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage flushes
- new_pc  out  ADDR_W  redirect target, valid while if_flush=1

Behaviour:
- Control registers:
  - 0 STATUS: bit0 exe_mode, bit1 ie
  - 1 PRE_STATUS
  - 2 EPC
  - 3 EXP_VECTOR
  - 4 CAUSE: [2:0] exp code
  - 5 INT_MASK: 1 = masked
  - 6 INT_PEND: read-only, synchronised irq
  - Other addresses read 0, writes ignored.
- Reset (reset=0, async): STATUS=0 (kernel, ie=0), PRE_STATUS=0, EPC=0, CAUSE=0, INT_MASK all 1s, EXP_VECTOR=EXP_VECTOR_RST, irq synchronisers 0, state RUN. All stall and flush outputs are 0; new_pc=0.
- irq passes through a 2-flop synchroniser into INT_PEND. Latency from irq to INT_PEND is 2 cycles.
- int_detect = ie & |(INT_PEND & ~INT_MASK), registered, so 1 further cycle.
- creg_rd_data is combinational from current register values. A same-cycle WRCR to the same address returns the old value; no bypass.
- Commit condition: commit = mem_en & ~mem_busy & state==RUN.
- Stalls, in RUN:
  - if_stall = id_stall = ex_stall = mem_stall = if_busy | mem_busy | ld_hazard
  - ld_hazard alone also asserts ex_flush, which inserts a bubble into EX.
- Commit with mem_exp_code!=0:
  - PRE_STATUS<=STATUS, STATUS<=0, EPC<=mem_pc, CAUSE<=code
  - all four flushes =1 that cycle; new_pc=EXP_VECTOR
  - flushes override stalls
- Commit with EXRT and exp_code=0: STATUS<=PRE_STATUS, all flushes =1, new_pc=EPC.
- Commit with WRCR and exp_code=0: write creg[mem_dst_addr]<=mem_out at the clock edge. Addresses 6 and 7+ are ignored.
- An exception has priority over the ctrl_op of the same instruction.
- If mem_busy=1, nothing commits. Exception and EXRT wait until mem_busy drops, with all stages stalled.
- Flush outputs are combinational from commit and last exactly one cycle per commit.
- If reset asserts mid-stall, all outputs clear immediately.

Optional Feature:
- Macro: PIPE_CTRL_HALT_EN.
- With the macro defined, a HALT commit (exp_code=0) moves the FSM RUN->HALT.
  - In HALT, all stalls =1 and flushes =0.
  - HALT->RUN when int_detect=1. That cycle asserts all flushes with new_pc=mem_pc+1 and EPC<=mem_pc+1, so the interrupt is taken on resume.
- Without the macro, HALT is treated as NOP, and there is no HALT state, only RUN.

Test Plan:
- Reset with irq=0xFF -> all stalls/flushes 0, exe_mode=0, int_detect=0, creg 3 reads EXP_VECTOR_RST, creg 5 reads 0xFF.
- ld_hazard=1 for 1 cycle -> if/id/ex/mem_stall=1 and ex_flush=1 for exactly that cycle.
- WRCR addr 3 data 0x100, then an overflow commit at mem_pc=0x40 -> all flushes 1 cycle, new_pc=0x100, EPC=0x40, CAUSE=3, PRE_STATUS=old STATUS.
- STATUS=0x3 then trap, then EXRT -> after EXRT STATUS=0x3, new_pc=EPC, exe_mode=1.
- INT_MASK=0xFE, ie=1, pulse irq[0] -> int_detect=1 three cycles after the irq edge; irq[1] alone -> int_detect stays 0.
- Exception with mem_busy=1 for 3 cycles -> no flush and stalls held; flush in the cycle mem_busy drops. With PIPE_CTRL_HALT_EN: HALT then irq -> stalls held until int_detect, resume with new_pc=mem_pc+1.
